// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcodes, PC-select
// encodings and fetch-stage state type.
package cpu_pkg;

    localparam int INST_W = 8;

    localparam logic [3:0] OP_MOVE = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JAL  = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_BNZ  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_LI   = 4'hF;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BZ  = 2'b01;
    localparam logic [1:0] PC_BNZ = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_ERR
    } fetch_state_t;

    function automatic logic [3:0] op_of(
        input logic [INST_W-1:0] i
    );
        return i[7:4];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
interface fetch_unit_if #(
    parameter int PC_W = 8
);
    import cpu_pkg::*;

    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC selection: sequential, conditional relative branch or
// in-page jump, all wrapping modulo 2^PC_W.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [3:0]      imm,
    input  logic [1:0]      pc_control,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc_next
);

    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] br;
    logic [PC_W-1:0] jmp;

    assign seq = pc + PC_W'(1);
    assign br  = seq + {{(PC_W-4){imm[3]}}, imm};
    assign jmp = {pc[PC_W-1:4], imm};

    always_comb begin
        pc_next = seq;
        unique case (pc_control)
            PC_SEQ: pc_next = seq;
            PC_BZ:  pc_next = alu_zero ? br : seq;
            PC_BNZ: pc_next = alu_zero ? seq : br;
            PC_JMP: pc_next = jmp;
            default: pc_next = seq;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage; optional fetch watchdog under
// FETCH_TIMEOUT_EN parks the unit in S_ERR with a sticky fetch_err.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 15
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      imem,
    output logic [INST_W-1:0] inst,
    output logic [3:0]        op,
    output logic              inst_valid,
    input  logic              advance,
    input  logic              stall,
    input  logic [1:0]        pc_control,
    input  logic              alu_zero,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   link_addr,
    output logic              fetch_err
);

    fetch_state_t    state;
    logic            req_q;
    logic [PC_W-1:0] pc_next;

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc         (pc),
        .imm        (inst[3:0]),
        .pc_control (pc_control),
        .alu_zero   (alu_zero),
        .pc_next    (pc_next)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             timeout_hit;

    assign timeout_hit = req_q && !imem.imem_ack &&
                         (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign fetch_err   = err_q;
`else
    assign fetch_err   = 1'b0;
`endif

    // Request is registered, so the first fetch after reset
    // starts one cycle late; later fetches start on retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            req_q      <= 1'b0;
            pc         <= PC_W'(RESET_PC);
            inst       <= '0;
            inst_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem.imem_ack) begin
                        inst       <= imem.imem_rdata;
                        inst_valid <= 1'b1;
                        req_q      <= 1'b0;
                        state      <= S_ISSUE;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt   <= '0;
                    end else if (timeout_hit) begin
                        req_q      <= 1'b0;
                        err_q      <= 1'b1;
                        state      <= S_ERR;
                    end else begin
                        wait_cnt   <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                S_ISSUE: begin
                    if (advance && !stall) begin
                        inst_valid <= 1'b0;
                        pc         <= pc_next;
                        req_q      <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_ERR: begin
                    req_q      <= 1'b0;
                    inst_valid <= 1'b0;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign op             = op_of(inst);
    assign link_addr      = pc + PC_W'(1);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, next-PC modes,
// stall priority, async reset and the optional fetch watchdog.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] inst;
    logic [3:0] op;
    logic       inst_valid;
    logic       advance;
    logic       stall;
    logic [1:0] pc_control;
    logic       alu_zero;
    logic [7:0] pc;
    logic [7:0] link_addr;
    logic       fetch_err;

    int errors = 0;
    int checks = 0;

    fetch_unit_if #(.PC_W(8)) bus ();

    fetch_unit #(
        .PC_W     (8),
        .RESET_PC (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (bus),
        .inst       (inst),
        .op         (op),
        .inst_valid (inst_valid),
        .advance    (advance),
        .stall      (stall),
        .pc_control (pc_control),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .link_addr  (link_addr),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fetch(input logic [7:0] data, input int waits);
        int n = 0;
        while (!bus.imem_req && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", 32'(bus.imem_req), 32'd1);
        repeat (waits) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        chk("fetch_valid", 32'(inst_valid), 32'd1);
        chk("fetch_inst", 32'(inst), 32'(data));
    endtask

    task automatic retire(input logic [1:0] ctl, input logic z);
        pc_control = ctl;
        alu_zero   = z;
        advance    = 1'b1;
        @(negedge clk);
        advance    = 1'b0;
    endtask

    task automatic step(input logic [7:0] data,
                        input logic [1:0] ctl,
                        input logic z);
        fetch(data, 0);
        retire(ctl, z);
    endtask

    initial begin
        rst_n          = 1'b0;
        advance        = 1'b0;
        stall          = 1'b0;
        pc_control     = 2'b00;
        alu_zero       = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_inst", 32'(inst), 32'h00);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // request held four cycles, ack on the fourth
        for (int i = 0; i < 4; i++) begin
            chk("hold_req", 32'(bus.imem_req), 32'd1);
            chk("hold_addr", 32'(bus.imem_addr), 32'h00);
            if (i == 3) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = 8'h15;
            end
            @(negedge clk);
        end
        bus.imem_ack = 1'b0;
        chk("t1_inst", 32'(inst), 32'h15);
        chk("t1_op", 32'(op), 32'h1);
        chk("t1_valid", 32'(inst_valid), 32'd1);
        chk("t1_pc", 32'(pc), 32'h00);
        chk("t1_req", 32'(bus.imem_req), 32'd0);

        // ack while idle after reset must be ignored
        do_reset();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 8'hEE;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("idle_ack", 32'(inst_valid), 32'd0);

        // bz taken: 0 -> 8 -> 0x10 -> 0x14
        do_reset();
        step(8'h07, PC_BZ, 1'b1);
        step(8'h07, PC_BZ, 1'b1);
        chk("walk_pc10", 32'(pc), 32'h10);
        fetch(8'hC3, 1);
        chk("bz_op", 32'(op), 32'hC);
        retire(PC_BZ, 1'b1);
        chk("bz_taken", 32'(pc), 32'h14);
        chk("bz_req", 32'(bus.imem_req), 32'd1);

        do_reset();
        step(8'h07, PC_BZ, 1'b1);
        step(8'h07, PC_BZ, 1'b1);
        fetch(8'hC3, 0);
        retire(PC_BZ, 1'b0);
        chk("bz_not", 32'(pc), 32'h11);

        do_reset();
        step(8'h07, PC_BZ, 1'b1);
        step(8'h07, PC_BZ, 1'b1);
        fetch(8'hDC, 2);
        retire(PC_BNZ, 1'b0);
        chk("bnz_neg", 32'(pc), 32'h0D);

        // walk to 0x38, jump to 0x3A, then jump to 0x35
        do_reset();
        for (int i = 0; i < 7; i++) step(8'h07, PC_BZ, 1'b1);
        chk("walk_pc38", 32'(pc), 32'h38);
        step(8'h8A, PC_JMP, 1'b0);
        chk("jmp_3a", 32'(pc), 32'h3A);
        fetch(8'h85, 0);
        chk("link_3b", 32'(link_addr), 32'h3B);
        chk("jmp_op", 32'(op), 32'h8);
        retire(PC_JMP, 1'b1);
        chk("jmp_35", 32'(pc), 32'h35);

        // backward branch wraps to 0xFF, sequential wraps to 0
        do_reset();
        step(8'h0E, PC_BZ, 1'b1);
        chk("br_wrap", 32'(pc), 32'hFF);
        chk("link_wrap", 32'(link_addr), 32'h00);
        step(8'h40, PC_SEQ, 1'b1);
        chk("seq_wrap", 32'(pc), 32'h00);

        // stall beats advance
        fetch(8'hA7, 0);
        stall      = 1'b1;
        advance    = 1'b1;
        pc_control = PC_JMP;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pc", 32'(pc), 32'h00);
            chk("stall_inst", 32'(inst), 32'hA7);
            chk("stall_valid", 32'(inst_valid), 32'd1);
        end
        stall   = 1'b0;
        advance = 1'b0;
        retire(PC_JMP, 1'b0);
        chk("post_stall", 32'(pc), 32'h07);
        chk("post_valid", 32'(inst_valid), 32'd0);

        // async reset during a fetch with ack in the same cycle
        chk("mid_req", 32'(bus.imem_req), 32'd1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.imem_req), 32'd0);
        chk("arst_pc", 32'(pc), 32'h00);
        chk("arst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        chk("arst_inst", 32'(inst), 32'h00);
        bus.imem_ack = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        chk("arst_rereq", 32'(bus.imem_req), 32'd1);

        // no ack for a long time
        do_reset();
        @(negedge clk);
        repeat (14) @(negedge clk);
        chk("to_early", 32'(fetch_err), 32'd0);
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_req", 32'(bus.imem_req), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 8'h55;
        repeat (3) @(negedge clk);
        bus.imem_ack   = 1'b0;
        chk("to_sticky", 32'(fetch_err), 32'd1);
        chk("to_novalid", 32'(inst_valid), 32'd0);
        do_reset();
        chk("to_clear", 32'(fetch_err), 32'd0);
`else
        chk("nto_err", 32'(fetch_err), 32'd0);
        chk("nto_req", 32'(bus.imem_req), 32'd1);
        chk("nto_addr", 32'(bus.imem_addr), 32'h00);
        fetch(8'h3C, 0);
        chk("nto_late_err", 32'(fetch_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
